// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage pipe, including the data-memory wait freeze.
// Define PIPE_HAZARD_TIMEOUT_EN to compile in the WAIT watchdog (WaitCnt, ERR state, MemTimeout).
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemTimeout,
    output logic [1:0] CtrlState
);

    // state    | meaning
    // ST_RUN   | normal flow; load-use stalls and branch flushes
    // ST_WAIT  | data memory busy; whole pipe frozen, bubbles into M/W
    // ST_ERR   | watchdog trap; frozen until reset
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   mem_wait, lw_stall, freeze;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign mem_wait = MemReqM & ~MemReadyM;
    assign lw_stall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

`ifdef PIPE_HAZARD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!MemReadyM) begin
                    freeze = 1'b1;
`ifdef PIPE_HAZARD_TIMEOUT_EN
                    if (wait_cnt_q == WAIT_LAST)
                        state_d = ST_ERR;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A freeze overrides the load-use bubble and the branch flush; both are re-evaluated on release.
    always_comb begin
        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
        FlushW = 1'b0;
        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

`ifdef PIPE_HAZARD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q != ST_WAIT)
                wait_cnt_q <= '0;
            else if (!MemReadyM)
                wait_cnt_q <= wait_cnt_q + CW'(1);
            timeout_q <= (state_d == ST_ERR);
        end
    end

    assign MemTimeout = timeout_q;
`else
    assign MemTimeout = 1'b0;
`endif

    assign CtrlState = state_q;

endmodule
